// File: rtl/arithmetic_left_shift_saturating_serial.sv
// Serial signed multiply-by-2^s: shifts one bit per clock, tracks signed overflow
// before every step and saturates the result toward the operand's sign.
module arithmetic_left_shift_saturating_serial #(
   parameter int N  = 8,
   parameter int SW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          up_vld,
   output logic          up_rdy,
   input  logic [N-1:0]  up_a,
   input  logic [SW-1:0] up_s,
   output logic          down_vld,
   input  logic          down_rdy,
   output logic [N-1:0]  down_res,
   output logic          down_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam logic [N-1:0]  SAT_MAX  = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0]  SAT_MIN  = {1'b1, {(N-1){1'b0}}};
   localparam logic [N-1:0]  ACC_ZERO = {N{1'b0}};
   localparam logic [SW-1:0] CNT_ZERO = {SW{1'b0}};
   localparam logic [SW-1:0] CNT_ONE  = SW'(1'b1);

   state_t        state_r;
   state_t        state_nx_s;
   logic [N-1:0]  acc_r;
   logic [N-1:0]  acc_nx_s;
   logic [SW-1:0] cnt_r;
   logic [SW-1:0] cnt_nx_s;
   logic          sign_r;
   logic          sign_nx_s;
   logic          ovf_r;
   logic          ovf_nx_s;
   logic          up_rdy_s;
   logic          down_vld_s;
   logic          load_out_s;
   logic [N-1:0]  down_res_r;
   logic          down_ovf_r;

   // A shift step loses the sign when the two top bits disagree.
   function automatic logic step_ovf(input logic [N-1:0] acc);
      step_ovf = acc[N-1] ^ acc[N-2];
   endfunction

   function automatic logic [N-1:0] saturate(input logic [N-1:0] acc,
                                             input logic ovf,
                                             input logic sign);
      if (!ovf) begin
         saturate = acc;
      end else if (sign) begin
         saturate = SAT_MIN;
      end else begin
         saturate = SAT_MAX;
      end
   endfunction

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (up_vld) begin
               if (up_s != CNT_ZERO) begin
                  state_nx_s = SHIFT;
               end else begin
                  state_nx_s = DONE;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         SHIFT: begin
            if (cnt_r == CNT_ONE) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = SHIFT;
            end
         end
         DONE: begin
            if (down_rdy) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Handshake outputs decoded from state only
   always_comb begin
      up_rdy_s   = 1'b0;
      down_vld_s = 1'b0;
      case (state_r)
         IDLE: begin
            up_rdy_s = 1'b1;
         end
         DONE: begin
            down_vld_s = 1'b1;
         end
         default: begin
            up_rdy_s   = 1'b0;
            down_vld_s = 1'b0;
         end
      endcase
   end

   // Datapath next values: load on accept, one shift per SHIFT cycle
   always_comb begin
      acc_nx_s  = acc_r;
      cnt_nx_s  = cnt_r;
      sign_nx_s = sign_r;
      ovf_nx_s  = ovf_r;
      case (state_r)
         IDLE: begin
            if (up_vld) begin
               acc_nx_s  = up_a;
               cnt_nx_s  = up_s;
               sign_nx_s = up_a[N-1];
               ovf_nx_s  = 1'b0;
            end else begin
               acc_nx_s = acc_r;
            end
         end
         SHIFT: begin
            ovf_nx_s = ovf_r | step_ovf(acc_r);
            acc_nx_s = {acc_r[N-2:0], 1'b0};
            cnt_nx_s = cnt_r - CNT_ONE;
         end
         default: begin
            acc_nx_s = acc_r;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r  <= ACC_ZERO;
         cnt_r  <= CNT_ZERO;
         sign_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         acc_r  <= acc_nx_s;
         cnt_r  <= cnt_nx_s;
         sign_r <= sign_nx_s;
         ovf_r  <= ovf_nx_s;
      end
   end

   // Result is captured only on entry to DONE so it stays frozen under backpressure.
   always_comb begin
      if ((state_nx_s == DONE) && (state_r != DONE)) begin
         load_out_s = 1'b1;
      end else begin
         load_out_s = 1'b0;
      end
   end

   // Registered result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         down_res_r <= ACC_ZERO;
         down_ovf_r <= 1'b0;
      end else if (load_out_s) begin
         down_res_r <= saturate(acc_nx_s, ovf_nx_s, sign_nx_s);
         down_ovf_r <= ovf_nx_s;
      end else begin
         down_res_r <= down_res_r;
         down_ovf_r <= down_ovf_r;
      end
   end

   assign up_rdy   = up_rdy_s;
   assign down_vld = down_vld_s;
   assign down_res = down_res_r;
   assign down_ovf = down_ovf_r;

endmodule

// File: tb/tb_arithmetic_left_shift_saturating_serial.sv
// Directed bench for the serial saturating left shifter: an arithmetic reference
// model checked every cycle, plus literal expectations that pin the model.
module tb_arithmetic_left_shift_saturating_serial;

   localparam int N  = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          up_vld = 1'b0;
   logic          up_rdy;
   logic [N-1:0]  up_a = '0;
   logic [SW-1:0] up_s = '0;
   logic          down_vld;
   logic          down_rdy = 1'b1;
   logic [N-1:0]  down_res;
   logic          down_ovf;

   arithmetic_left_shift_saturating_serial #(.N(N), .SW(SW)) dut (
      .clk(clk), .rst(rst),
      .up_vld(up_vld), .up_rdy(up_rdy), .up_a(up_a), .up_s(up_s),
      .down_vld(down_vld), .down_rdy(down_rdy),
      .down_res(down_res), .down_ovf(down_ovf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int timeouts = 0;
   int cyc_n = 0;
   bit done = 1'b0;

   // literal expectations, written by stimulus, consumed by the compare process
   logic [N-1:0] lit_res [0:31];
   logic         lit_ovf [0:31];
   int           lit_s   [0:31];
   int           lit_wr = 0;
   int           lit_rd = 0;

   // reference model: true product a*2^s, clamped to the signed N-bit range
   function automatic logic [N:0] model_op(input int a, input int s);
      longint p;
      longint maxv;
      longint minv;
      maxv = (longint'(1) << (N - 1)) - 1;
      minv = -(longint'(1) << (N - 1));
      p = longint'(a) * (longint'(1) << s);
      if (p > maxv) p = maxv + 2 * (longint'(1) << N);
      if (p > maxv) return {1'b1, maxv[N-1:0]};
      if (p < minv) return {1'b1, minv[N-1:0]};
      return {1'b0, p[N-1:0]};
   endfunction

   logic         m_busy = 1'b0;
   logic         m_valid = 1'b0;
   logic         m_fresh = 1'b1;
   int           m_wait = 0;
   logic [N:0]   m_pend = '0;
   logic [N-1:0] m_res;
   logic         m_ovf;
   assign m_res = m_pend[N-1:0];
   assign m_ovf = m_pend[N];

   // protocol model: accept in idle, valid s edges later, hold until consumed
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_valid <= 1'b0; m_wait <= 0; m_pend <= '0; m_fresh <= 1'b1;
      end else if (m_valid) begin
         if (down_rdy) m_valid <= 1'b0;
      end else if (m_busy) begin
         if (m_wait == 1) begin
            m_busy <= 1'b0; m_valid <= 1'b1; m_fresh <= 1'b0;
         end else begin
            m_wait <= m_wait - 1;
         end
      end else if (up_vld) begin
         m_pend <= model_op(int'($signed(up_a)), int'(up_s));
         if (up_s == '0) begin
            m_valid <= 1'b1; m_fresh <= 1'b0;
         end else begin
            m_busy <= 1'b1; m_wait <= int'(up_s);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc_n);
      end
   endtask

   logic prev_vld = 1'b0;
   bit   lat_on = 1'b0;
   int   lat_cnt = 0;

   // compare process: DUT against model every cycle, literals at each new result
   always @(negedge clk) begin
      cyc_n++;
      chk("up_rdy", 32'(up_rdy), 32'(!(m_busy || m_valid)));
      chk("down_vld", 32'(down_vld), 32'(m_valid));
      if (m_valid) begin
         chk("down_res", 32'(down_res), 32'(m_res));
         chk("down_ovf", 32'(down_ovf), 32'(m_ovf));
      end
      if (m_fresh) begin
         chk("res_after_reset", 32'(down_res), 32'd0);
         chk("ovf_after_reset", 32'(down_ovf), 32'd0);
      end
      if (rst) begin
         lat_on <= 1'b0;
      end else begin
         if (lat_on) lat_cnt <= lat_cnt + 1;
         if (down_vld && !prev_vld) begin
            chk("literal_pending", 32'(lit_wr > lit_rd), 32'd1);
            if (lit_wr > lit_rd) begin
               chk("res_vs_literal", 32'(down_res), 32'(lit_res[lit_rd]));
               chk("ovf_vs_literal", 32'(down_ovf), 32'(lit_ovf[lit_rd]));
               chk("model_vs_literal", 32'(m_pend), 32'({lit_ovf[lit_rd], lit_res[lit_rd]}));
               if (lat_on) chk("latency", 32'(lat_cnt + 1), 32'(lit_s[lit_rd] + 1));
               lit_rd <= lit_rd + 1;
            end
            lat_on <= 1'b0;
         end
         if (up_vld && up_rdy) begin
            lat_on <= 1'b1;
            lat_cnt <= 0;
         end
      end
      prev_vld <= down_vld;
      if (done) begin
         chk("wait_timeouts", 32'(timeouts), 32'd0);
         chk("results_consumed", 32'(lit_rd), 32'(lit_wr));
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
      if (cyc_n > 20000) begin
         $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc_n);
         $fatal(1, "watchdog");
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic push_lit(input int s, input logic [N-1:0] res, input logic ovf);
      lit_s[lit_wr] = s;
      lit_res[lit_wr] = res;
      lit_ovf[lit_wr] = ovf;
      lit_wr++;
   endtask

   task automatic wait_rdy();
      for (int i = 0; i < 50; i++) begin
         if (up_rdy) break;
         cyc();
      end
      if (!up_rdy) timeouts++;
   endtask

   task automatic wait_vld();
      for (int i = 0; i < 50; i++) begin
         if (down_vld) break;
         cyc();
      end
      if (!down_vld) timeouts++;
   endtask

   task automatic issue(input int a, input int s);
      wait_rdy();
      up_vld = 1'b1;
      up_a = N'(a);
      up_s = SW'(s);
      cyc();
      up_vld = 1'b0;
   endtask

   task automatic run_op(input int a, input int s, input int exp_res, input logic exp_ovf);
      push_lit(s, N'(exp_res), exp_ovf);
      issue(a, s);
      wait_vld();
      cyc();
   endtask

   initial begin
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      // arithmetic cases with hand-computed results
      run_op(3, 2, 12, 1'b0);
      run_op(50, 2, 127, 1'b1);
      run_op(-20, 3, -128, 1'b1);
      run_op(-16, 3, -128, 1'b0);
      run_op(-1, 7, -128, 1'b0);
      run_op(0, 7, 0, 1'b0);
      run_op(-5, 0, -5, 1'b0);
      run_op(64, 1, 127, 1'b1);
      run_op(-64, 1, -128, 1'b0);
      run_op(-128, 1, -128, 1'b1);
      run_op(127, 7, 127, 1'b1);
      run_op(1, 6, 64, 1'b0);
      run_op(-3, 5, -96, 1'b0);
      // backpressure: result held, competing operand ignored until released
      down_rdy = 1'b0;
      push_lit(1, N'(14), 1'b0);
      push_lit(1, N'(127), 1'b1);
      issue(7, 1);
      wait_vld();
      up_vld = 1'b1;
      up_a = N'(100);
      up_s = SW'(1);
      repeat (5) cyc();
      down_rdy = 1'b1;
      cyc();
      cyc();
      up_vld = 1'b0;
      wait_vld();
      cyc();
      // reset in the middle of a shift discards the operation
      issue(9, 5);
      cyc();
      cyc();
      #1 rst = 1'b1;
      cyc();
      rst = 1'b0;
      run_op(1, 1, 2, 1'b0);
      run_op(-5, 0, -5, 1'b0);
      repeat (2) cyc();
      done = 1'b1;
   end

endmodule

// File: doc/arithmetic_left_shift_saturating_serial.md
# arithmetic_left_shift_saturating_serial

Sequential signed multiply-by-power-of-2: accepts a signed N-bit operand and a shift amount, shifts left one bit per clock, and detects signed overflow, saturating the result on overflow. It complements the combinational arithmetic-right-shift (signed divide by 2^S) blocks in the arithmetic section. It sits between a valid/ready producer and a valid/ready consumer, one operation in flight at a time.

## Interface

- N, default 8: operand and result width, two's complement, N ≥ 2.
- SW, default 3: shift-amount width; max shift 2^SW − 1.

- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- up_vld  input  1  operand valid.
- up_rdy  output  1  block can accept an operand.
- up_a  input  N  signed operand.
- up_s  input  SW  unsigned shift amount.
- down_vld  output  1  result valid.
- down_rdy  input  1  consumer accepts the result.
- down_res  output  N  signed result: up_a · 2^up_s, saturated.
- down_ovf  output  1  result saturated (true product not representable in N bits).

## Operation

- States: IDLE, SHIFT, DONE. Registers: acc[N], cnt[SW], sign (sign of up_a), ovf.
- IDLE: up_rdy = 1. On up_vld & up_rdy: acc ← up_a, cnt ← up_s, sign ← up_a[N−1], ovf ← 0; next state SHIFT if up_s ≠ 0, else DONE.
- SHIFT: up_rdy = 0. Each cycle: if acc[N−1] ≠ acc[N−2], ovf ← 1 (sticky); acc ← {acc[N−2:0], 1'b0}; cnt ← cnt − 1; when cnt = 1 at this edge, next state DONE.
- DONE: down_vld = 1, up_rdy = 0. down_res = acc if ovf = 0; otherwise 2^(N−1) − 1 when sign = 0, −2^(N−1) when sign = 1. down_ovf = ovf. On down_rdy: next state IDLE.
- down_res and down_ovf are held stable for the whole time down_vld = 1; outside DONE their values are don't-care but must be 0 after reset until the first DONE.
- Overflow is checked before every shift step, so −2^(N−1) is reachable without overflow (e.g. −1 << N−1).
- a = 0 never overflows for any shift amount.
- up_vld while up_rdy = 0 is ignored; the producer must hold it.

## Timing

- Reset (asynchronous, immediate): state IDLE, up_rdy = 1, down_vld = 0, down_res = 0, down_ovf = 0, acc/cnt/ovf/sign = 0.
- Latency: accept at edge k → down_vld = 1 after edge k + up_s + 1 (up_s = 0 → 1 cycle).
- Throughput with down_rdy held 1: one operation per up_s + 2 cycles; up_rdy goes high the cycle after the output handshake.
- Handshake on down_rdy arriving the same cycle down_vld rises: consumed at that edge, IDLE next cycle.
- down_rdy low: stays in DONE indefinitely, outputs unchanged.
- Reset asserted in SHIFT or DONE: operation discarded, no output handshake, all outputs return to reset values.
- Outputs are registered or decoded from state only; no combinational path from up_* or down_rdy to any output.

## Test plan

- N=8: a=3, s=2 → after 3 cycles down_vld=1, down_res=12, down_ovf=0; up_rdy=0 throughout SHIFT.
- a=50, s=2 → down_res=127, down_ovf=1; a=−20, s=3 → down_res=−128, down_ovf=1.
- a=−16, s=3 → down_res=−128, down_ovf=0; a=−1, s=7 → −128, down_ovf=0; a=0, s=7 → 0, down_ovf=0.
- a=−5, s=0 → down_vld one cycle after accept, down_res=−5, down_ovf=0.
- Backpressure: a=7, s=1, down_rdy=0 for 5 cycles → down_vld stays 1, down_res=14 stable, new up_vld ignored; release → IDLE next cycle, then new operand accepted.
- Assert rst mid-SHIFT (a=9, s=5, after 2 cycles) → down_vld=0, down_res=0, up_rdy=1 immediately; next operand a=1, s=1 → 2 with correct latency.
